// File: rtl/random_roller_pkg.sv
// Shared types and elaboration helpers for the decelerating random roller.
// Everything here is constant-evaluated; nothing builds hardware by itself.
package random_roller_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ROLL = 1'b1
    } state_e;

    // Width of an index/counter that must hold 0..v-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 32'd2) ? 32'd1 : $clog2(v);
    endfunction

    // LFSR step period for a stage; each later stage doubles the period.
    function automatic longint unsigned step_period(
        input longint unsigned stage_cycles,
        input int unsigned     base_shift,
        input int unsigned     stg
    );
        return stage_cycles >> (base_shift - stg);
    endfunction

endpackage

// File: rtl/roller_lfsr.sv
// Fibonacci right-shift LFSR with load and step enables; zero states are never
// loaded, because an all-zero LFSR would lock up.
module roller_lfsr
    import random_roller_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED   = 16'h0003,
    parameter int                OUT_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_step,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    output logic [OUT_W-1:0]  o_value,
    output logic [OUT_W-1:0]  o_next_value
);

    localparam logic [LFSR_W-1:0] ONE     = LFSR_W'(1);
    localparam logic [LFSR_W-1:0] RST_VAL = (SEED == '0) ? ONE : SEED;

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [LFSR_W-1:0] stepped;

    assign stepped = {^(lfsr_q & TAPS), lfsr_q[LFSR_W-1:1]};

    always_comb begin
        lfsr_d = lfsr_q;
        if (i_load) begin
            lfsr_d = (i_seed == '0) ? ONE : i_seed;
        end else if (i_step) begin
            lfsr_d = stepped;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr_q <= RST_VAL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_value      = lfsr_q[OUT_W-1:0];
    assign o_next_value = stepped[OUT_W-1:0];

endmodule

// File: rtl/random_roller.sv
// Slowing-dice roller: an LFSR steps at a rate that halves every stage, the
// final value is frozen and kept in a newest-first history for the display.
module random_roller
    import random_roller_pkg::*;
#(
    parameter int                LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] TAPS         = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED         = 16'h0003,
    parameter int                OUT_W        = 4,
    parameter int                N_STAGES     = 5,
    parameter int unsigned       STAGE_CYCLES = 10_000_000,
    parameter int unsigned       BASE_SHIFT   = 5,
    parameter int                HIST_DEPTH   = 4
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_start,
    input  logic                                 i_stop,
    input  logic                                 i_seed_load,
    input  logic [LFSR_W-1:0]                    i_seed,
    input  logic                                 i_hist_show,
    input  logic [clog2_min1(HIST_DEPTH)-1:0]    i_hist_sel,
    output logic [OUT_W-1:0]                     o_random_out,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic [$clog2(HIST_DEPTH+1)-1:0]      o_hist_cnt
);

    localparam int CNT_W  = clog2_min1(STAGE_CYCLES);
    localparam int STG_W  = clog2_min1(N_STAGES);
    localparam int HCNT_W = $clog2(HIST_DEPTH + 1);

    localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(N_STAGES - 1);
    localparam logic [HCNT_W-1:0] HIST_FULL = HCNT_W'(HIST_DEPTH);

    state_e             state_q, state_d;
    logic [STG_W-1:0]   stg_q, stg_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   tick_q, tick_d;
    logic               done_q, done_d;
    logic [HCNT_W-1:0]  hist_cnt_q, hist_cnt_d;

    logic [HIST_DEPTH-1:0][OUT_W-1:0] hist_q;
    logic [HIST_DEPTH-1:0][OUT_W-1:0] hist_d;

    logic               lfsr_step;
    logic               lfsr_load;
    logic               push;
    logic [OUT_W-1:0]   live_val;
    logic [OUT_W-1:0]   next_val;
    logic [OUT_W-1:0]   push_val;

    // Per-stage terminal tick count, folded to constants at elaboration.
    logic [N_STAGES-1:0][CNT_W-1:0] period_m1;

    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_period
        localparam longint unsigned PERIOD =
            step_period(64'(STAGE_CYCLES), BASE_SHIFT, gi);
        assign period_m1[gi] = CNT_W'(PERIOD - 64'd1);
    end

    roller_lfsr #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .SEED   (SEED),
        .OUT_W  (OUT_W)
    ) u_lfsr (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_step       (lfsr_step),
        .i_load       (lfsr_load),
        .i_seed       (i_seed),
        .o_value      (live_val),
        .o_next_value (next_val)
    );

    always_comb begin
        state_d   = state_q;
        stg_d     = stg_q;
        cyc_d     = cyc_q;
        tick_d    = tick_q;
        done_d    = 1'b0;
        lfsr_step = 1'b0;
        lfsr_load = 1'b0;
        push      = 1'b0;

        unique case (state_q)
            IDLE: begin
                lfsr_load = i_seed_load;
                if (i_start) begin
                    state_d = ROLL;
                    stg_d   = '0;
                    cyc_d   = '0;
                    tick_d  = '0;
                end
            end
            ROLL: begin
                if (i_stop) begin
                    state_d = IDLE;
                end else if (i_start) begin
                    stg_d  = '0;
                    cyc_d  = '0;
                    tick_d = '0;
                end else begin
                    cyc_d  = cyc_q + 1'b1;
                    tick_d = tick_q + 1'b1;
                    if (tick_q == period_m1[stg_q]) begin
                        lfsr_step = 1'b1;
                        tick_d    = '0;
                    end
                    // Stage boundary; the step above still lands on this cycle.
                    if (cyc_q == CYC_LAST) begin
                        cyc_d  = '0;
                        tick_d = '0;
                        if (stg_q == STG_LAST) begin
                            state_d = IDLE;
                            stg_d   = '0;
                            done_d  = 1'b1;
                            push    = 1'b1;
                        end else begin
                            stg_d = stg_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The recorded result is the value after the final step, not before it.
    assign push_val = lfsr_step ? next_val : live_val;

    for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist
        if (gi == 0) begin : g_head
            assign hist_d[gi] = push ? push_val : hist_q[gi];
        end else begin : g_tail
            assign hist_d[gi] = push ? hist_q[gi-1] : hist_q[gi];
        end
    end

    assign hist_cnt_d = (push && (hist_cnt_q != HIST_FULL)) ? hist_cnt_q + 1'b1
                                                              : hist_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            stg_q      <= '0;
            cyc_q      <= '0;
            tick_q     <= '0;
            done_q     <= 1'b0;
            hist_q     <= '0;
            hist_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            stg_q      <= stg_d;
            cyc_q      <= cyc_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            hist_q     <= hist_d;
            hist_cnt_q <= hist_cnt_d;
        end
    end

    always_comb begin
        o_random_out = live_val;
        if ((state_q == IDLE) && i_hist_show) begin
            o_random_out = '0;
            if (HCNT_W'(i_hist_sel) < hist_cnt_q) begin
                o_random_out = hist_q[i_hist_sel];
            end
        end
    end

    assign o_busy     = (state_q == ROLL);
    assign o_done     = done_q;
    assign o_hist_cnt = hist_cnt_q;

endmodule

// File: tb/tb_random_roller.sv
// Scoreboard bench for random_roller on a 4-bit LFSR: stimulus queues the
// expected roll result, a negedge monitor checks it whenever o_done pulses.
module tb_random_roller;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_stop = 1'b0;
    logic       i_seed_load = 1'b0;
    logic [3:0] i_seed = 4'd0;
    logic       i_hist_show = 1'b0;
    logic [1:0] i_hist_sel = 2'd0;
    logic [3:0] o_random_out;
    logic       o_busy;
    logic       o_done;
    logic [2:0] o_hist_cnt;

    always #5 clk = ~clk;

    random_roller #(
        .LFSR_W       (4),
        .TAPS         (4'b1001),
        .SEED         (4'd3),
        .OUT_W        (4),
        .N_STAGES     (3),
        .STAGE_CYCLES (32),
        .BASE_SHIFT   (3),
        .HIST_DEPTH   (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_seed_load  (i_seed_load),
        .i_seed       (i_seed),
        .i_hist_show  (i_hist_show),
        .i_hist_sel   (i_hist_sel),
        .o_random_out (o_random_out),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_hist_cnt   (o_hist_cnt)
    );

    // Hand-computed orbit of taps 1001 starting from 3 (period 15).
    logic [3:0] seq_tab [15] = '{4'd3, 4'd9, 4'd4, 4'd2, 4'd1, 4'd8, 4'd12, 4'd14,
                                 4'd15, 4'd7, 4'd11, 4'd5, 4'd10, 4'd13, 4'd6};

    typedef struct {
        logic [3:0] val;
        logic [2:0] cnt;
    } exp_t;

    exp_t       done_q[$];
    logic [3:0] hist_m[$];
    int         idx = 0;
    int         cnt_m = 0;
    int         checks = 0;
    int         failures = 0;
    int         done_seen = 0;
    int         rolls_expected = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input int steps);
        exp_t e;
        idx = (idx + steps) % 15;
        cnt_m = (cnt_m < 4) ? cnt_m + 1 : 4;
        hist_m.push_front(seq_tab[idx]);
        if (hist_m.size() > 4) void'(hist_m.pop_back());
        e.val = seq_tab[idx];
        e.cnt = 3'(cnt_m);
        done_q.push_back(e);
        rolls_expected++;
    endtask

    task automatic show_chk(input string name, input int sel);
        logic [3:0] exp;
        exp = (sel < hist_m.size()) ? hist_m[sel] : 4'd0;
        i_hist_show = 1'b1;
        i_hist_sel  = 2'(sel);
        #1;
        chk(name, 32'(o_random_out), 32'(exp));
        i_hist_show = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (3) tick();
        i_rst = 1'b0;
        idx = 0;
        cnt_m = 0;
        hist_m.delete();
    endtask

    // A complete uninterrupted roll; optionally checks every step value.
    task automatic run_roll(input bit detailed);
        int busy_n = 0;
        int chg = 0;
        int d0;
        int idx0;
        logic [3:0] prev;
        idx0 = idx;
        d0 = done_seen;
        push_expect(14);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        prev = o_random_out;
        for (int k = 0; k < 200 && o_busy; k++) begin
            busy_n++;
            tick();
            if (o_random_out !== prev) begin
                if (detailed) begin
                    chk("roll_step_value", 32'(o_random_out),
                        32'(seq_tab[(idx0 + chg + 1) % 15]));
                    if (chg == 0) chk("first_step_latency", 32'(k + 1), 32'd4);
                end
                chg++;
                prev = o_random_out;
            end
        end
        chk("roll_busy_cycles", 32'(busy_n), 32'd96);
        chk("roll_step_count", 32'(chg), 32'd14);
        tick();
        tick();
        chk("roll_done_pulses", 32'(done_seen - d0), 32'd1);
        $display("roll: final=%0d hist_cnt=%0d", o_random_out, o_hist_cnt);
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports completion.
    always @(negedge clk) begin
        if (o_done === 1'b1) begin
            exp_t e;
            done_seen++;
            $display("done: value=%0d hist_cnt=%0d", o_random_out, o_hist_cnt);
            if (done_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = done_q.pop_front();
                chk("done_value", 32'(o_random_out), 32'(e.val));
                chk("done_hist_cnt", 32'(o_hist_cnt), 32'(e.cnt));
                chk("done_busy_low", 32'(o_busy), 32'd0);
            end
        end
    end

    initial begin
        int busy_n;
        int d0;

        // Reset state
        do_reset();
        chk("reset_out", 32'(o_random_out), 32'd3);
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_done", 32'(o_done), 32'd0);
        chk("reset_hist_cnt", 32'(o_hist_cnt), 32'd0);
        show_chk("reset_hist_sel0", 0);

        // Single detailed roll, then four more to saturate the history
        run_roll(1'b1);
        chk("roll1_hist_cnt", 32'(o_hist_cnt), 32'd1);
        show_chk("roll1_hist_sel0", 0);
        show_chk("roll1_hist_sel1_empty", 1);
        for (int r = 0; r < 4; r++) run_roll(1'b0);
        chk("sat_hist_cnt", 32'(o_hist_cnt), 32'd4);
        for (int s = 0; s < 4; s++) show_chk("sat_hist_sel", s);

        // Restart sampled on cycle 41 of a roll: 9 steps, then a full roll
        d0 = done_seen;
        push_expect(23);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (40) tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        busy_n = 0;
        for (int k = 0; k < 200 && o_busy; k++) begin
            busy_n++;
            tick();
        end
        chk("restart_busy_cycles", 32'(busy_n), 32'd96);
        tick();
        tick();
        chk("restart_done_pulses", 32'(done_seen - d0), 32'd1);
        $display("restart: final=%0d", o_random_out);

        // Stop sampled on cycle 50: 10 steps taken, no push
        d0 = done_seen;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (49) tick();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        idx = (idx + 10) % 15;
        chk("stop_busy", 32'(o_busy), 32'd0);
        chk("stop_out", 32'(o_random_out), 32'(seq_tab[idx]));
        repeat (5) tick();
        chk("stop_out_frozen", 32'(o_random_out), 32'(seq_tab[idx]));
        chk("stop_hist_cnt", 32'(o_hist_cnt), 32'd4);
        chk("stop_no_done", 32'(done_seen - d0), 32'd0);
        $display("stop: out=%0d", o_random_out);

        // Stop and start together on cycle 22: stop wins after 5 steps
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (21) tick();
        i_stop = 1'b1;
        i_start = 1'b1;
        tick();
        i_stop = 1'b0;
        i_start = 1'b0;
        idx = (idx + 5) % 15;
        chk("stopstart_busy", 32'(o_busy), 32'd0);
        tick();
        chk("stopstart_busy_after", 32'(o_busy), 32'd0);
        chk("stopstart_out", 32'(o_random_out), 32'(seq_tab[idx]));
        chk("stopstart_no_done", 32'(done_seen - d0), 32'd0);
        $display("stop+start: out=%0d", o_random_out);

        // Zero seed in IDLE becomes 1
        i_seed = 4'd0;
        i_seed_load = 1'b1;
        tick();
        i_seed_load = 1'b0;
        chk("seed_zero_out", 32'(o_random_out), 32'd1);
        idx = 4;
        $display("seed load: out=%0d", o_random_out);

        // Seed load during ROLL is ignored
        d0 = done_seen;
        push_expect(14);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (9) tick();
        i_seed_load = 1'b1;
        tick();
        i_seed_load = 1'b0;
        for (int k = 0; k < 200 && o_busy; k++) tick();
        tick();
        tick();
        chk("rollload_done_pulses", 32'(done_seen - d0), 32'd1);

        // Reset mid-roll
        d0 = done_seen;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (29) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        idx = 0;
        cnt_m = 0;
        hist_m.delete();
        chk("midrst_out", 32'(o_random_out), 32'd3);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_hist_cnt", 32'(o_hist_cnt), 32'd0);
        tick();
        chk("midrst_no_done", 32'(done_seen - d0), 32'd0);
        $display("mid-roll reset: out=%0d", o_random_out);

        // One roll after reset; entries beyond the count read as 0
        run_roll(1'b1);
        chk("post_rst_hist_cnt", 32'(o_hist_cnt), 32'd1);
        for (int s = 0; s < 4; s++) show_chk("post_rst_hist_sel", s);

        chk("scoreboard_drained", 32'(done_q.size()), 32'd0);
        chk("total_done_pulses", 32'(done_seen), 32'(rolls_expected));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/random_roller.md
Name: random_roller

Overview:
- Parametrised successor of the lab-1 decelerating random-number generator.
- On start, an LFSR advances at a rate that halves across N_STAGES fixed-length stages ("slowing dice"). The final value is then frozen and pushed into a HIST_DEPTH-deep history.
- Entirely single-clock: LFSR stepping uses a clock-enable tick, never a derived clock. Drives the lab seven-segment display path.

Parameters:
- LFSR_W, 16, LFSR state width (>=4).
- TAPS, 16'hB400, feedback tap mask, LFSR_W bits.
- SEED, 16'h0003, reset state; a zero value is replaced by 1.
- OUT_W, 4, output width, <= LFSR_W.
- N_STAGES, 5, number of deceleration stages (>=1).
- STAGE_CYCLES, 10_000_000, clock cycles per stage.
- BASE_SHIFT, 5, stage-0 step period = STAGE_CYCLES >> BASE_SHIFT. Must satisfy BASE_SHIFT >= N_STAGES-1 and the period must be >= 1.
- HIST_DEPTH, 4, number of finished results retained (>=1).

Ports:
- i_clk, in, 1, clock.
- i_rst, in, 1, reset.
- i_start, in, 1, level-sampled start/restart request.
- i_stop, in, 1, abort the current roll.
- i_seed_load, in, 1, load i_seed into the LFSR (IDLE only).
- i_seed, in, LFSR_W, seed value.
- i_hist_show, in, 1, 1 = display a history entry while IDLE.
- i_hist_sel, in, $clog2(HIST_DEPTH) (min 1), history index; 0 = newest.
- o_random_out, out, OUT_W, displayed value.
- o_busy, out, 1, roll in progress.
- o_done, out, 1, one-cycle pulse when a roll completes.
- o_hist_cnt, out, $clog2(HIST_DEPTH+1), valid history entries.

Interface rule: one clock, i_clk; reset i_rst is synchronous and active-high.

Behaviour:
- Reset (synchronous, active-high):
  - LFSR = SEED (1 if SEED==0); state IDLE.
  - All counters 0; history entries 0; o_hist_cnt=0.
  - o_busy=0, o_done=0, o_random_out = SEED[OUT_W-1:0].
  - Reset mid-roll aborts the roll with no history push.
- States: IDLE, ROLL. The stage index stg (0..N_STAGES-1) and counters are registers.
- LFSR step (Fibonacci, right shift): new_msb = ^(lfsr & TAPS); lfsr <= {new_msb, lfsr[LFSR_W-1:1]}. Output value = lfsr[OUT_W-1:0].
- Step period P(stg) = STAGE_CYCLES >> (BASE_SHIFT - stg), so each stage doubles the period.
- IDLE:
  - i_start=1 -> ROLL next cycle. stg=0, cyc_cnt=0, tick_cnt=0, o_busy=1 from that cycle.
  - i_seed_load=1 (and no i_start) -> lfsr <= i_seed (0 becomes 1).
  - If i_start and i_seed_load are both asserted, the seed is loaded and the roll starts on the same edge.
- ROLL, every cycle:
  - cyc_cnt and tick_cnt increment.
  - When tick_cnt == P(stg)-1: step the LFSR, tick_cnt <= 0.
  - When cyc_cnt == STAGE_CYCLES-1: cyc_cnt <= 0, tick_cnt <= 0, stg++. The step on this cycle still happens.
  - When the last cycle of stage N_STAGES-1 completes:
    - state <= IDLE, o_busy <= 0, o_done <= 1 for one cycle.
    - Push the post-step output value into history[0], shifting older entries; the oldest entry drops.
    - o_hist_cnt saturates at HIST_DEPTH.
  - Roll length = N_STAGES*STAGE_CYCLES cycles. LFSR steps per roll = sum over stages of 2^(BASE_SHIFT-stg).
- Priority in ROLL: i_stop > i_start > normal.
  - i_stop: go to IDLE, no push, no o_done; LFSR holds its current value.
  - i_start: restart at stg=0 with counters cleared; LFSR is not reseeded.
- i_seed_load is ignored in ROLL.
- o_random_out:
  - ROLL: live LFSR value.
  - IDLE with i_hist_show=1: history[i_hist_sel] (combinational select). Gives 0 if i_hist_sel >= o_hist_cnt.
  - Otherwise: live value.
- Arithmetic: counter widths are $clog2(STAGE_CYCLES); all compares are unsigned.

Decomposition:
- Package random_roller_pkg: state enum (IDLE, ROLL), a localparam function for P(stg), and width helpers.
- One sub-module, roller_lfsr: parametrised LFSR with i_step, i_load, i_seed and zero-seed guard.
- The history shift register stays inline.

Test Plan (LFSR_W=4, TAPS=4'b1001, SEED=3, OUT_W=4, N_STAGES=3, STAGE_CYCLES=32, BASE_SHIFT=3, HIST_DEPTH=4; periods 4/8/16, 14 steps/roll):
- Reset then idle -> o_random_out=3, o_busy=0, o_hist_cnt=0.
- Single i_start pulse -> output sequence 9,4,2,1,8,12,14,15,7,11,5,10,13,6. First change 4 cycles after o_busy rises. o_busy high exactly 96 cycles, o_done pulses once, history[0]=6, o_hist_cnt=1.
- Five back-to-back rolls -> o_hist_cnt saturates at 4. With i_hist_show=1, i_hist_sel=0..3 show the newest-first results; i_hist_sel beyond the count shows 0 after reset-and-one-roll.
- i_start re-asserted at cycle 40 of a roll -> stg returns to 0, roll ends 96 cycles after the restart, single o_done.
- i_stop at cycle 50 -> o_busy=0 next cycle, no o_done, o_hist_cnt unchanged, output frozen. i_stop+i_start together -> stop wins.
- i_seed_load with i_seed=0 in IDLE -> output 1. The same load during ROLL is ignored. i_rst mid-roll -> output 3, o_hist_cnt=0.
